// File: rtl/velocity_estimator.sv
// Quadrature encoder decoder with windowed velocity measurement.
// Synchronizes the A/B channels, decodes x4 quadrature into signed steps,
// tracks absolute position and counts steps over fixed windows of
// SAMPLE_PERIOD cycles, emitting a saturated 16-bit velocity per window.
module velocity_estimator #(
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter int unsigned ACC_WIDTH     = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  output logic signed [15:0] raw_signed_velocity,
  output logic               velocity_valid,
  output logic signed [31:0] position,
  output logic               quad_error,
  output logic [7:0]         error_count
);

  localparam logic [23:0] WIN_LAST = 24'(SAMPLE_PERIOD - 1);

  // Synchronizer stages and fill tracker
  logic       a_s1, a_s2, b_s1, b_s2;
  logic [1:0] sync_fill;

  // Decode state
  logic a_prev, b_prev, primed;

  // Combinational decode results
  logic [1:0]        cur_phase, prev_phase, phase_delta;
  logic signed [1:0] step;
  logic              illegal;

  // Window datapath
  logic [23:0]                 win_cnt;
  logic                        terminal;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH:0]   acc_sum;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-15:0]       sum_hi;
  logic signed [15:0]          win_sat;
  logic signed [31:0]          step_ext;

  // Two-flop synchronizers; sync_fill marks when the second flop holds a real pin sample
  always_ff @(posedge clk) begin
    if (reset) begin
      a_s1      <= 1'b0;
      a_s2      <= 1'b0;
      b_s1      <= 1'b0;
      b_s2      <= 1'b0;
      sync_fill <= '0;
    end else begin
      a_s1      <= enc_a;
      a_s2      <= a_s1;
      b_s1      <= enc_b;
      b_s2      <= b_s1;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Priming waits for the synchronizer to fill so the cleared flops are never
  // mistaken for an encoder state (avoids a false 00->11 error after reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      a_prev <= 1'b0;
      b_prev <= 1'b0;
      primed <= 1'b0;
    end else if (primed || sync_fill[1]) begin
      a_prev <= a_s2;
      b_prev <= b_s2;
      primed <= 1'b1;
    end
  end

  // Gray-to-binary phase difference: +1 forward, -1 reverse, 2 illegal
  always_comb begin
    cur_phase   = {a_s2, a_s2 ^ b_s2};
    prev_phase  = {a_prev, a_prev ^ b_prev};
    phase_delta = cur_phase - prev_phase;
    step        = 2'sb00;
    illegal     = 1'b0;
    if (primed) begin
      case (phase_delta)
        2'd1:    step = 2'sb01;
        2'd3:    step = 2'sb11;
        2'd2:    illegal = 1'b1;
        default: step = 2'sb00;
      endcase
    end
  end

  // Position tracking and illegal-transition bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      position    <= '0;
      quad_error  <= 1'b0;
      error_count <= '0;
    end else begin
      position <= position + step_ext;
      if (illegal) begin
        quad_error <= 1'b1;
        if (error_count != 8'hFF) begin
          error_count <= error_count + 8'd1;
        end
      end
    end
  end

  // Saturating accumulator next value and 16-bit window result
  always_comb begin
    step_ext = {{30{step[1]}}, step};
    terminal = (win_cnt == WIN_LAST);
    acc_sum  = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH - 1){step[1]}}, step};
    if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1]) begin
      acc_next = {acc_sum[ACC_WIDTH], {(ACC_WIDTH - 1){~acc_sum[ACC_WIDTH]}}};
    end else begin
      acc_next = acc_sum[ACC_WIDTH-1:0];
    end
    sum_hi = acc_sum[ACC_WIDTH:15];
    if ((&sum_hi) || !(|sum_hi)) begin
      win_sat = acc_sum[15:0];
    end else if (acc_sum[ACC_WIDTH]) begin
      win_sat = 16'sh8000;
    end else begin
      win_sat = 16'sh7FFF;
    end
  end

  // Window counter, accumulator and velocity strobe; a terminal-cycle step closes into its own window
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt             <= '0;
      acc                 <= '0;
      raw_signed_velocity <= '0;
      velocity_valid      <= 1'b0;
    end else begin
      velocity_valid <= terminal;
      if (terminal) begin
        raw_signed_velocity <= win_sat;
        acc                 <= '0;
        win_cnt             <= '0;
      end else begin
        acc     <= acc_next;
        win_cnt <= win_cnt + 24'd1;
      end
    end
  end

endmodule
